ex_mdu: RTL and testbench
=========================

# ex_mdu

Multiply/divide unit for the EX stage of the five-stage pipelined CPU, placed beside the ALU and fed from the same forwarded A/B operand buses. It runs MULT/MULTU/DIV/DIVU over several cycles into private HI/LO registers and executes MTHI/MTLO in a single cycle. HI/LO are exported continuously for MFHI/MFLO. A busy flag tells the hazard unit to stall multiply/divide-class instructions in ID.

## Interface
- MUL_CYCLES, 5, cycles from multiply accept to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from divide accept to HI/LO update (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  op valid this cycle (EX stage holds an MDU instruction)
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- A  in  32  operand rs (forwarded); MTHI/MTLO source
- B  in  32  operand rt (forwarded)
- busy  out  1  multi-cycle op in flight
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset (rst_n=0 at a clk edge): hi=0, lo=0, busy=0, cycle counter=0. Takes priority over everything, including an op already in flight, which is aborted.
- States: IDLE, RUN.
- Accept condition: start=1 in IDLE with a valid op.
- IDLE, MULT-class or DIV-class accepted:
  - latch A, B and op
  - load counter with MUL_CYCLES or DIV_CYCLES
  - go to RUN
- IDLE, MTHI/MTLO accepted: hi←A or lo←A at that edge. Stay in IDLE; busy stays 0.
- IDLE, reserved op: no state change.
- RUN: decrement counter each edge. On the edge where the counter reaches 0:
  - write {hi,lo}
  - return to IDLE
- start while in RUN is ignored. The hazard unit must not issue it; the bench checks it is dropped.
- Results are computed from the latched operands only. A/B changing during RUN has no effect.
- Arithmetic:
  - MULT: {hi,lo} = signed(A)×signed(B), full 64 bits.
  - MULTU: same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV overflow, A=0x80000000 and B=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=A. This is defined behaviour, not X.
- Pending multi-cycle ops are never flushed; the only abort is reset.

## Timing
- Accept at edge N:
  - busy=1 from edge N through edge N+LAT−1 (LAT = MUL_CYCLES or DIV_CYCLES).
  - hi/lo take the new value at edge N+LAT.
  - busy=0 after edge N+LAT.
- Back-to-back: a new start can be accepted at edge N+LAT+1 at the earliest, when busy is first seen low.
- MTHI/MTLO: 1-cycle write, visible on hi/lo the cycle after the accept edge.
- Hazard rule for the stall logic, stated here for verification:
  - Stall an MDU-class instruction (MULT*, DIV*, MF*, MT*) in ID while (start && op is MULT/DIV-class) || busy.
  - MFHI/MFLO read hi/lo combinationally in EX.
- hi, lo and busy are all register outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package (cpu_defs):
  - op encoding constants MDU_MULT…MDU_MTLO
  - default latencies MUL_CYCLES=5, DIV_CYCLES=10
  - ID-stage decode and hazard logic use the same constants.
- One sub-module, mdu_arith:
  - purely combinational
  - inputs: latched A, B, op
  - output: 64-bit {hi,lo} result, including the signed fix-ups, overflow case and divide-by-zero case
- ex_mdu owns the FSM, counter and operand/HI/LO registers.

## Test plan
- Reset then idle: rst_n low for 2 cycles → hi=lo=0, busy=0. MTHI A=0x12345678 → hi=0x12345678 next cycle, busy stays 0.
- MULT, A=0xFFFFFFFE (−2), B=3:
  - busy high exactly 5 cycles
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA
  - MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA
- DIV, A=0xFFFFFFF9 (−7), B=2:
  - after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - DIVU 7/2 → lo=3, hi=1
- Boundaries:
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0
  - DIVU A=5, B=0 → lo=0xFFFFFFFF, hi=5
- start=1 (MTLO 0xAAAA) pulsed mid-RUN of a MULT:
  - the MTLO is ignored
  - hi/lo end with the MULT result
  - busy falls at the expected cycle
  - A/B toggled during RUN do not change the result
- rst_n=0 asserted at cycle 3 of a DIV → next cycle busy=0, hi=lo=0, and no late write occurs.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared MDU op encodings, default latencies and decode helper
package cpu_defs;
  typedef logic [2:0] mdu_op_t;
  localparam mdu_op_t MDU_MULT  = 3'b000;
  localparam mdu_op_t MDU_MULTU = 3'b001;
  localparam mdu_op_t MDU_DIV   = 3'b010;
  localparam mdu_op_t MDU_DIVU  = 3'b011;
  localparam mdu_op_t MDU_MTHI  = 3'b100;
  localparam mdu_op_t MDU_MTLO  = 3'b101;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
  function automatic logic is_muldiv(mdu_op_t op);
    return !op[2];
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [63:0] res
);
  logic sgn;
  logic [31:0] ma, mb, uq, ur;
  logic [63:0] prod;
  always_comb begin
    sgn  = !op[0];
    prod = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'b0, a} * {32'b0, b};
    ma   = sgn && a[31] ? -a : a;
    mb   = sgn && b[31] ? -b : b;
    uq   = mb == 32'b0 ? '1 : ma / mb;
    ur   = mb == 32'b0 ? a : ma % mb;
    // signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0
    res  = !op[1] ? prod :
           b == 32'b0 ? {a, 32'hFFFF_FFFF} :
           {sgn && a[31] ? -ur : ur, sgn && (a[31] ^ b[31]) ? -uq : uq};
  end
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit with private HI/LO and busy flag
module ex_mdu #(
  parameter int MUL_CYCLES = cpu_defs::MUL_CYCLES,
  parameter int DIV_CYCLES = cpu_defs::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic state;
  logic [CW-1:0] cnt;
  logic [31:0] ra, rb;
  logic [1:0] rop;
  logic [63:0] res;
  assign busy = state == RUN;
  mdu_arith u_arith (.a(ra), .b(rb), .op(rop), .res(res));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      rop   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        {hi, lo} <= res;
        state    <= IDLE;
      end
    end else if (start) begin
      if (cpu_defs::is_muldiv(op)) begin
        ra    <= A;
        rb    <= B;
        rop   <= op[1:0];
        cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        state <= RUN;
      end else if (op == cpu_defs::MDU_MTHI) hi <= A;
      else if (op == cpu_defs::MDU_MTLO) lo <= A;
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized self-checking bench for ex_mdu against an arithmetic reference model
module tb_ex_mdu;
  logic clk = 0, rst_n = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] A = 0, B = 0;
  logic busy;
  logic [31:0] hi, lo;
  logic [31:0] mhi = 0, mlo = 0;
  int nvec = 0, nfail = 0;

  ex_mdu dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
              .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [2:0] o, logic [31:0] a, logic [31:0] b, logic [63:0] cur);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd0) return 64'(sa * sb);
    if (o == 3'd1) return {32'b0, a} * {32'b0, b};
    if ((o == 3'd2 || o == 3'd3) && b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (o == 3'd3) return {a % b, a / b};
    if (o == 3'd4) return {a, cur[31:0]};
    if (o == 3'd5) return {cur[63:32], a};
    return cur;
  endfunction

  function automatic int lat(logic [2:0] o);
    return o < 2 ? 5 : o < 4 ? 10 : 0;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [63:0] exp_r;
    int l;
    exp_r = model(o, a, b, {mhi, mlo});
    l = lat(o);
    start = 1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 0;
    if (disturb) begin A = $urandom; B = $urandom; end
    for (int k = 0; k < l; k++) begin
      nvec++;
      if (busy !== 1'b1 || {hi, lo} !== {mhi, mlo}) begin
        nfail++;
        $display("FAIL run_busy op=%0d cyc=%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h", o, k, busy, hi, lo, mhi, mlo);
      end
      if (disturb && k == 2) begin start = 1; op = 3'd5; A = 32'h0000_AAAA; end
      @(posedge clk); #1;
      start = 0;
      if (disturb) begin A = $urandom; B = $urandom; end
    end
    nvec++;
    if (busy !== 1'b0 || {hi, lo} !== exp_r) begin
      nfail++;
      $display("FAIL result op=%0d a=%h b=%h: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h", o, a, b, busy, hi, lo, exp_r[63:32], exp_r[31:0]);
    end
    {mhi, mlo} = exp_r;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      nfail++;
      $display("FAIL reset: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    rst_n = 1; mhi = 0; mlo = 0;
  endtask

  task automatic test_mt();
    run_op(3'd4, 32'h1234_5678, $urandom, 0);
    nvec++;
    if (hi !== 32'h1234_5678) begin nfail++; $display("FAIL mthi_const: hi=%h, want 12345678", hi); end
    run_op(3'd5, $urandom, $urandom, 0);
    run_op(3'd6, $urandom, $urandom, 0);
    run_op(3'd7, $urandom, $urandom, 0);
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    nvec++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin nfail++; $display("FAIL mult_const: hi=%h lo=%h, want ffffffff fffffffa", hi, lo); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    nvec++;
    if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin nfail++; $display("FAIL multu_const: hi=%h lo=%h, want 00000002 fffffffa", hi, lo); end
    for (int i = 0; i < 16; i++) run_op(3'($urandom_range(0, 1)), $urandom, $urandom, 0);
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    nvec++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin nfail++; $display("FAIL div_const: hi=%h lo=%h, want ffffffff fffffffd", hi, lo); end
    run_op(3'd3, 32'd7, 32'd2, 0);
    nvec++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin nfail++; $display("FAIL divu_const: hi=%h lo=%h, want 00000001 00000003", hi, lo); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    nvec++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin nfail++; $display("FAIL div_ovf: hi=%h lo=%h, want 00000000 80000000", hi, lo); end
    run_op(3'd3, 32'd5, 32'd0, 0);
    nvec++;
    if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin nfail++; $display("FAIL divu_zero: hi=%h lo=%h, want 00000005 ffffffff", hi, lo); end
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, 0);
    for (int i = 0; i < 16; i++)
      run_op(3'($urandom_range(2, 3)), $urandom,
             $urandom_range(0, 3) == 0 ? 32'd0 : $urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 300)) : $urandom, 0);
  endtask

  task automatic test_ignore_start();
    run_op(3'd0, 32'h0001_2345, 32'hFFFF_0010, 1);
    run_op(3'd3, $urandom, 32'($urandom_range(1, 1000)), 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 7) == 0 ? 32'd0 : $urandom, 0);
  endtask

  task automatic test_reset_abort();
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0);
    start = 1; op = 3'd2; A = 32'd1000; B = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    nvec++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      nfail++;
      $display("FAIL abort_reset: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        nfail++;
        $display("FAIL abort_late cyc=%0d: busy=%b hi=%h lo=%h, want 0 0 0", k, busy, hi, lo);
      end
    end
    mhi = 0; mlo = 0;
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    run_op(3'd0, $urandom, $urandom, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
